fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage for the 16-bit pipelined core.
- Consumer end of the next-PC interface: owns the architectural PC register and takes redirect targets from the branch/PC-control logic.
- Issues requests to a variable-latency instruction memory and presents the fetched instruction, its PC and PC+2 to the IF/ID boundary.
- Obeys stall from the hazard unit and stops on HLT.

Parameters:
- RESET_PC, 16'h0000: PC value loaded on reset.
- HALT_OPCODE, 4'b1111: instr[15:12] value that halts fetch.
- PC_STEP, 2: sequential PC increment in bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect  in  1  taken branch/flush; load redirect_pc.
- redirect_pc  in  16  target address from PC control (valid only with redirect).
- stall  in  1  IF/ID cannot accept; hold outputs.
- imem_req  out  1  one-cycle request strobe.
- imem_addr  out  16  request address (equals PC while imem_req=1).
- imem_valid  in  1  response strobe; exactly one per request; earliest the cycle after imem_req.
- imem_data  in  16  instruction word, valid with imem_valid.
- if_valid  out  1  if_instr/if_pc/if_pc_plus2 hold a live instruction.
- if_instr  out  16  fetched instruction.
- if_pc  out  16  address of if_instr.
- if_pc_plus2  out  16  if_pc + 2, modulo 2^16.
- halted  out  1  fetch stopped on HLT.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=REQ, drop=0.
  - if_valid=0, if_instr=16'h0000, if_pc=16'h0000, if_pc_plus2=16'h0002.
  - imem_req=0 (combinational from state, gated by rst_n), halted=0.
- States: REQ, WAIT, HOLD, HALTED.
- REQ:
  - imem_req=1, imem_addr=pc.
  - Next state WAIT.
  - If redirect is high in this cycle, the request still issues, drop is set to 1 and pc<=redirect_pc.
- WAIT, on imem_valid with drop=0:
  - Registered outputs update next edge: if_instr<=imem_data, if_pc<=pc, if_pc_plus2<=pc+2, if_valid<=1, pc<=pc+PC_STEP.
  - If imem_data[15:12]==HALT_OPCODE, next state HALTED.
  - Otherwise next state HOLD if stall, else REQ.
- WAIT, on imem_valid with drop=1: discard the response, drop<=0, next state REQ (pc already holds the target).
- WAIT, on redirect: pc<=redirect_pc, drop<=1, if_valid<=0. Redirect and imem_valid in the same cycle means the response is discarded.
- Output consumption: if_valid clears to 0 the cycle after consumption (stall=0 while if_valid=1) unless a new response loads.
- HOLD:
  - Outputs frozen, no request.
  - Leave to REQ when stall=0.
  - Redirect: pc<=redirect_pc, if_valid<=0, next state REQ.
- HALTED:
  - halted=1, no requests. The HLT word stays on if_* with if_valid=1 until consumed once, then if_valid=0.
  - Redirect means the HLT was on a squashed path: halted<=0, if_valid<=0, pc<=redirect_pc, next state REQ.
  - Otherwise HALTED holds until reset.
- Priority: reset > redirect > imem_valid capture > stall.
- Latency: imem_req at cycle N, imem_valid at N+1 gives if_valid at N+2. Sustained throughput with 1-cycle memory is one instruction every 2 cycles.
- Arithmetic: all PC math is 16-bit unsigned and wraps (16'hFFFE+2 = 16'h0000). PC bit 0 is forwarded unmodified.
- Reset mid-WAIT: the outstanding response is ignored because the memory is reset on the same rst_n.

Decomposition:
- Shared package cpu_pkg:
  - PC_W=16, opcode constants OP_B=4'b1100, OP_BR=4'b1101, OP_HLT=4'b1111.
  - fetch_state_t enum {REQ, WAIT, HOLD, HALTED}.
- One sub-module, pc_reg: 16-bit register with async active-low reset to RESET_PC, a load enable, and a mux between pc+PC_STEP and redirect_pc.

Test Plan:
- Reset, then 1-cycle memory returning 16'h1234 at addr 0 and 16'h5678 at addr 2 -> imem_addr 0,2,4; if_instr 16'h1234 with if_pc 0 and if_pc_plus2 2, then 16'h5678 with if_pc 2; if_valid high 2 cycles after each req.
- Stall held 3 cycles while if_valid=1 -> if_* frozen, imem_req=0 throughout; next req addr = if_pc+2 one cycle after stall drops.
- Redirect to 16'h0040 during WAIT, memory returns 16'hAAAA -> 16'hAAAA never seen on if_valid; next imem_addr=16'h0040.
- Fetch 16'hF000 at addr 6 -> halted=1, if_instr=16'hF000 valid once, no further imem_req; then redirect to 16'h0010 -> halted=0, imem_addr=16'h0010.
- pc=16'hFFFE fetch -> if_pc_plus2=16'h0000, next imem_addr=16'h0000.
- rst_n low mid-WAIT with drop=1 -> all outputs at reset values immediately; first req after release at addr RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined core.
// Contents:
//   PC_W                 - architectural PC / instruction width
//   OP_B, OP_BR, OP_HLT  - opcode values found in instr[15:12]
//   fetch_state_t        - fetch-stage FSM encoding
package cpu_pkg;

    localparam int PC_W = 16;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        REQ    = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Architectural PC register for the fetch stage.
// Ports:
//   clk_i          - clock, rising edge
//   rst_ni         - asynchronous active-low reset, loads RESET_PC
//   load_i         - update the PC this cycle
//   sel_redirect_i - 1: load redirect_pc_i, 0: load pc + PC_STEP
//   redirect_pc_i  - redirect target
//   pc_o           - current PC
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            sel_redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Sequential increment wraps modulo 2^16; bit 0 passes through untouched.
    assign pc_d = sel_redirect_i ? redirect_pc_i : (pc_q + PC_W'(PC_STEP));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else if (load_i) begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to a
// variable-latency instruction memory and presents the fetched word, its PC
// and PC+2 to the IF/ID boundary.
// Handshake: imem_req is a one-cycle strobe with imem_addr == pc; exactly one
// imem_valid comes back, no earlier than the following cycle. The IF/ID side
// consumes if_* on any cycle where if_valid=1 and stall=0.
// Ports:
//   clk, rst_n                  - clock / async active-low reset
//   redirect, redirect_pc       - taken branch / flush with its target
//   stall                       - IF/ID cannot accept, hold outputs
//   imem_req, imem_addr         - memory request strobe and address
//   imem_valid, imem_data       - memory response strobe and word
//   if_valid, if_instr, if_pc, if_pc_plus2 - IF/ID payload
//   halted                      - fetch stopped on HLT
//   dbg_state_o                 - current FSM state
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]      HALT_OPCODE = OP_HLT,
    parameter int              PC_STEP     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            stall,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [PC_W-1:0] imem_data,
    output logic            if_valid,
    output logic [PC_W-1:0] if_instr,
    output logic [PC_W-1:0] if_pc,
    output logic [PC_W-1:0] if_pc_plus2,
    output logic            halted,
    output fetch_state_t    dbg_state_o
);

    fetch_state_t    state_q, state_d;
    logic            drop_q, drop_d;
    logic            if_valid_q, if_valid_d;
    logic [PC_W-1:0] if_instr_q, if_instr_d;
    logic [PC_W-1:0] if_pc_q, if_pc_d;
    logic [PC_W-1:0] if_pc_plus2_q, if_pc_plus2_d;
    logic            pc_load, pc_sel_redirect;
    logic [PC_W-1:0] pc;

    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .load_i         (pc_load),
        .sel_redirect_i (pc_sel_redirect),
        .redirect_pc_i  (redirect_pc),
        .pc_o           (pc)
    );

    always_comb begin
        state_d         = state_q;
        drop_d          = drop_q;
        // An unstalled cycle with if_valid=1 is a consumption.
        if_valid_d      = if_valid_q & stall;
        if_instr_d      = if_instr_q;
        if_pc_d         = if_pc_q;
        if_pc_plus2_d   = if_pc_plus2_q;
        pc_load         = 1'b0;
        pc_sel_redirect = 1'b0;

        // Redirect wins over everything but reset and always flushes IF/ID.
        if (redirect) begin
            pc_load         = 1'b1;
            pc_sel_redirect = 1'b1;
            if_valid_d      = 1'b0;
        end

        case (state_q)
            REQ: begin
                // The request goes out regardless; a redirect marks it stale.
                state_d = WAIT;
                if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    if (imem_valid) begin
                        // Response arrives with the redirect: discard now.
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        pc_load       = 1'b1;
                        if_instr_d    = imem_data;
                        if_pc_d       = pc;
                        if_pc_plus2_d = pc + 16'd2;
                        if_valid_d    = 1'b1;
                        if (imem_data[15:12] == HALT_OPCODE) begin
                            state_d = HALTED;
                        end else if (stall) begin
                            state_d = HOLD;
                        end else begin
                            state_d = REQ;
                        end
                    end
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_d = REQ;
                end
            end
            HALTED: begin
                if (redirect) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= REQ;
            drop_q        <= 1'b0;
            if_valid_q    <= 1'b0;
            if_instr_q    <= 16'h0000;
            if_pc_q       <= 16'h0000;
            if_pc_plus2_q <= 16'h0002;
        end else begin
            state_q       <= state_d;
            drop_q        <= drop_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus2_q <= if_pc_plus2_d;
        end
    end

    // Gated by rst_n so no strobe escapes while reset is held.
    assign imem_req    = (state_q == REQ) && rst_n;
    assign imem_addr   = pc;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus2 = if_pc_plus2_q;
    assign halted      = (state_q == HALTED);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import cpu_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         redirect = 1'b0;
    logic [15:0]  redirect_pc = 16'h0000;
    logic         stall = 1'b0;
    logic         imem_req;
    logic [15:0]  imem_addr;
    logic         imem_valid = 1'b0;
    logic [15:0]  imem_data = 16'h0000;
    logic         if_valid;
    logic [15:0]  if_instr;
    logic [15:0]  if_pc;
    logic [15:0]  if_pc_plus2;
    logic         halted;
    fetch_state_t dbg_state;

    int checks = 0;
    int failures = 0;

    // clock / reset
    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus2 (if_pc_plus2),
        .halted      (halted),
        .dbg_state_o (dbg_state)
    );

    // instruction memory model: response appears in the cycle after the
    // request (plus extra_lat cycles), reset by the same rst_n
    logic [15:0] mem [logic [15:0]];
    logic        busy = 1'b0;
    logic [15:0] pend_addr = 16'h0000;
    int          wait_cnt = 0;
    int          extra_lat = 0;
    int          req_count = 0;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0000;
    endfunction

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_valid = 1'b0;
            busy       = 1'b0;
        end else begin
            imem_valid = 1'b0;
            if (busy) begin
                if (wait_cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_data  = mem_rd(pend_addr);
                    busy       = 1'b0;
                end else begin
                    wait_cnt = wait_cnt - 1;
                end
            end
            if (imem_req) begin
                busy      = 1'b1;
                pend_addr = imem_addr;
                wait_cnt  = extra_lat;
                req_count = req_count + 1;
            end
        end
    end

    // checking helpers
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to just after the next falling edge; words from squashed
    // paths (AAAA, BBBB) must never be presented as valid
    task automatic tick();
        @(negedge clk);
        #1;
        chk("no_squashed_word",
            {15'd0, (if_valid === 1'b1) && ((if_instr === 16'hAAAA) || (if_instr === 16'hBBBB))},
            16'd0);
    endtask

    task automatic chk_if(input string tag, input logic v, input logic [15:0] ins,
                          input logic [15:0] p, input logic [15:0] p2);
        chk({tag, "_valid"}, {15'd0, if_valid}, {15'd0, v});
        chk({tag, "_instr"}, if_instr, ins);
        chk({tag, "_pc"}, if_pc, p);
        chk({tag, "_pc_plus2"}, if_pc_plus2, p2);
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [15:0] a);
        chk({tag, "_req"}, {15'd0, imem_req}, {15'd0, r});
        if (r) chk({tag, "_addr"}, imem_addr, a);
    endtask

    int req_snap;

    initial begin
        mem[16'h0000] = 16'h1234;
        mem[16'h0002] = 16'h5678;
        mem[16'h0004] = 16'h0ABC;
        mem[16'h0006] = 16'hF000;
        mem[16'h0010] = 16'hBBBB;
        mem[16'h0040] = 16'hAAAA;
        mem[16'h0080] = 16'h2222;
        mem[16'hFFFE] = 16'h3333;

        // reset
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk_req("rst", 1'b0, 16'h0000);
        chk_if("rst", 1'b0, 16'h0000, 16'h0000, 16'h0002);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_state", {14'd0, dbg_state}, {14'd0, REQ});
        @(posedge clk);
        #2 rst_n = 1'b1;

        // sequential fetch with 1-cycle memory
        tick(); chk_req("n0", 1'b1, 16'h0000);
        tick(); chk_req("n1", 1'b0, 16'h0000); chk("n1_valid", {15'd0, if_valid}, 16'd0);
        tick(); chk_if("n2", 1'b1, 16'h1234, 16'h0000, 16'h0002); chk_req("n2", 1'b1, 16'h0002);
        tick(); chk("n3_consumed", {15'd0, if_valid}, 16'd0);
        tick(); chk_if("n4", 1'b1, 16'h5678, 16'h0002, 16'h0004); chk_req("n4", 1'b1, 16'h0004);

        // stall on capture -> HOLD for three cycles
        tick(); stall = 1'b1;
        tick(); chk_if("hold1", 1'b1, 16'h0ABC, 16'h0004, 16'h0006); chk_req("hold1", 1'b0, 16'h0000);
        chk("hold1_state", {14'd0, dbg_state}, {14'd0, HOLD});
        tick(); chk_if("hold2", 1'b1, 16'h0ABC, 16'h0004, 16'h0006); chk_req("hold2", 1'b0, 16'h0000);
        tick(); chk_if("hold3", 1'b1, 16'h0ABC, 16'h0004, 16'h0006); chk_req("hold3", 1'b0, 16'h0000);
        stall = 1'b0;
        tick(); chk_req("after_stall", 1'b1, 16'h0006); chk("after_stall_valid", {15'd0, if_valid}, 16'd0);
        req_snap = req_count;

        // HLT
        tick();
        tick(); chk("hlt_halted", {15'd0, halted}, 16'd1);
        chk_if("hlt", 1'b1, 16'hF000, 16'h0006, 16'h0008); chk_req("hlt", 1'b0, 16'h0000);
        tick(); chk("hlt_consumed", {15'd0, if_valid}, 16'd0); chk("hlt_halted2", {15'd0, halted}, 16'd1);
        tick(); chk_req("hlt_idle", 1'b0, 16'h0000);
        chk("hlt_no_req", req_count[15:0], req_snap[15:0]);
        chk("hlt_state", {14'd0, dbg_state}, {14'd0, HALTED});
        redirect = 1'b1; redirect_pc = 16'h0010;

        // leave HALTED, then redirect during REQ (stale response BBBB)
        tick(); chk("unhalt", {15'd0, halted}, 16'd0); chk_req("unhalt", 1'b1, 16'h0010);
        redirect_pc = 16'h0040;
        tick(); redirect = 1'b0; extra_lat = 1;
        tick(); chk_req("redir_req", 1'b1, 16'h0040); chk("redir_req_valid", {15'd0, if_valid}, 16'd0);

        // redirect during WAIT with a 2-cycle memory (stale response AAAA)
        tick(); redirect = 1'b1; redirect_pc = 16'h0080;
        tick(); redirect = 1'b0; extra_lat = 0;
        chk_req("redir_wait", 1'b0, 16'h0000); chk("redir_wait_valid", {15'd0, if_valid}, 16'd0);
        tick(); chk_req("redir_wait_next", 1'b1, 16'h0080);
        tick();
        tick(); chk_if("tgt", 1'b1, 16'h2222, 16'h0080, 16'h0082); chk_req("tgt", 1'b1, 16'h0082);

        // PC wrap at 16'hFFFE
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick(); redirect = 1'b0;
        tick(); chk_req("wrap_req", 1'b1, 16'hFFFE);
        tick();
        tick(); chk_if("wrap", 1'b1, 16'h3333, 16'hFFFE, 16'h0000); chk_req("wrap", 1'b1, 16'h0000);

        // reset while in WAIT with drop set
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick(); redirect = 1'b0;
        chk("drop_state", {14'd0, dbg_state}, {14'd0, WAIT});
        #2 rst_n = 1'b0;
        #1;
        chk_req("mid_rst", 1'b0, 16'h0000);
        chk_if("mid_rst", 1'b0, 16'h0000, 16'h0000, 16'h0002);
        chk("mid_rst_halted", {15'd0, halted}, 16'd0);
        tick();
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick(); chk_req("post_rst", 1'b1, 16'h0000);
        tick();
        tick(); chk_if("post_rst", 1'b1, 16'h1234, 16'h0000, 16'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
